// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_pkg
// Description : Shared sizing, sequencer state type and Q16.16 twiddles for
//               the 8-point radix-2 FFT core and its frame sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int N        = 8;
    localparam int DATA_W   = 32;
    localparam int CORE_LAT = 3;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_t;

    // W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N), k = 0..N/2-1, rounded to Q16.16
    localparam logic [DATA_W-1:0] TW_RE [N/2] = '{
        32'h0001_0000, 32'h0000_B505, 32'h0000_0000, 32'hFFFF_4AFB
    };
    localparam logic [DATA_W-1:0] TW_IM [N/2] = '{
        32'h0000_0000, 32'hFFFF_4AFB, 32'hFFFF_0000, 32'hFFFF_4AFB
    };

endpackage
`default_nettype wire

// File: rtl/fft_frame_buf.sv
`default_nettype none
// ============================================================================
// Module      : fft_frame_buf
// Description : N-slot register file with indexed write, whole-frame parallel
//               load and flat parallel read. Parallel load wins over write.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_frame_buf #(
    parameter int N      = fft_pkg::N,
    parameter int DATA_W = fft_pkg::DATA_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_wr_en,
    input  logic [$clog2(N)-1:0]   i_wr_idx,
    input  logic [DATA_W-1:0]      i_wr_data,
    input  logic                   i_load_en,
    input  logic [N*DATA_W-1:0]    i_load_data,
    output logic [N*DATA_W-1:0]    o_data
);

    localparam int IDX_W = $clog2(N);

    logic [DATA_W-1:0] r_slot [N];

    generate
        for (genvar k = 0; k < N; k++) begin : g_slot
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_slot[k] <= '0;
                end else if (i_load_en) begin
                    r_slot[k] <= i_load_data[k*DATA_W +: DATA_W];
                end else if (i_wr_en && (i_wr_idx == IDX_W'(k))) begin
                    r_slot[k] <= i_wr_data;
                end
            end

            assign o_data[k*DATA_W +: DATA_W] = r_slot[k];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/fft_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fft_frame_sequencer
// Description : Collects N samples for the parallel FFT core, waits out its
//               pipeline, captures the spectrum and streams bins in order.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_frame_sequencer #(
    parameter int N        = fft_pkg::N,
    parameter int DATA_W   = fft_pkg::DATA_W,
    parameter int CORE_LAT = fft_pkg::CORE_LAT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    output logic [N*DATA_W-1:0]   core_in_r,
    input  logic [N*DATA_W-1:0]   core_out_r,
    input  logic [N*DATA_W-1:0]   core_out_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_r,
    output logic [DATA_W-1:0]     out_i,
    output logic                  out_last,
    output logic                  frame_done,
    output logic                  busy
);

    import fft_pkg::*;

    localparam int                IDX_W    = $clog2(N);
    localparam int                WAIT_W   = $clog2(CORE_LAT + 1);
    localparam int                PAIR_W   = 2 * DATA_W;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);
    localparam logic [WAIT_W-1:0] LAT_END  = WAIT_W'(CORE_LAT);

    seq_state_t          r_state,    w_state_nxt;
    logic [IDX_W-1:0]    r_wr_idx,   w_wr_idx_nxt;
    logic [IDX_W-1:0]    r_rd_idx,   w_rd_idx_nxt;
    logic [WAIT_W-1:0]   r_wait_cnt, w_wait_nxt;
    logic                r_frame_done, w_done_nxt;
    logic                w_in_accept;
    logic                w_capture;
    logic [N*PAIR_W-1:0] w_core_pack;
    logic [N*PAIR_W-1:0] w_out_all;
    logic [PAIR_W-1:0]   w_out_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_FILL;
            r_wr_idx     <= '0;
            r_rd_idx     <= '0;
            r_wait_cnt   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wr_idx     <= w_wr_idx_nxt;
            r_rd_idx     <= w_rd_idx_nxt;
            r_wait_cnt   <= w_wait_nxt;
            r_frame_done <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_wr_idx_nxt = r_wr_idx;
        w_rd_idx_nxt = r_rd_idx;
        w_wait_nxt   = r_wait_cnt;
        w_done_nxt   = 1'b0;
        w_in_accept  = 1'b0;
        w_capture    = 1'b0;
        unique case (r_state)
            ST_FILL: begin
                if (in_valid) begin
                    w_in_accept = 1'b1;
                    if (r_wr_idx == LAST_IDX) begin
                        w_state_nxt  = ST_WAIT;
                        w_wr_idx_nxt = '0;
                        w_wait_nxt   = '0;
                    end else begin
                        w_wr_idx_nxt = r_wr_idx + 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                // Inputs have been frozen long enough for every core stage
                if (r_wait_cnt == LAT_END) begin
                    w_capture    = 1'b1;
                    w_state_nxt  = ST_DRAIN;
                    w_rd_idx_nxt = '0;
                end else begin
                    w_wait_nxt = r_wait_cnt + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (r_rd_idx == LAST_IDX) begin
                        w_state_nxt  = ST_FILL;
                        w_rd_idx_nxt = '0;
                        w_done_nxt   = 1'b1;
                    end else begin
                        w_rd_idx_nxt = r_rd_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_FILL;
            end
        endcase
    end

    fft_frame_buf #(
        .N      (N),
        .DATA_W (DATA_W)
    ) u_in_buf (
        .clk         (clk),
        .rst         (rst),
        .i_wr_en     (w_in_accept),
        .i_wr_idx    (r_wr_idx),
        .i_wr_data   (in_data),
        .i_load_en   (1'b0),
        .i_load_data ('0),
        .o_data      (core_in_r)
    );

    // Each output slot holds {imag, real} so one buffer serves both parts
    generate
        for (genvar k = 0; k < N; k++) begin : g_pack
            assign w_core_pack[k*PAIR_W +: PAIR_W] =
                {core_out_i[k*DATA_W +: DATA_W], core_out_r[k*DATA_W +: DATA_W]};
        end
    endgenerate

    fft_frame_buf #(
        .N      (N),
        .DATA_W (PAIR_W)
    ) u_out_buf (
        .clk         (clk),
        .rst         (rst),
        .i_wr_en     (1'b0),
        .i_wr_idx    ('0),
        .i_wr_data   ('0),
        .i_load_en   (w_capture),
        .i_load_data (w_core_pack),
        .o_data      (w_out_all)
    );

    assign w_out_sel  = w_out_all[r_rd_idx*PAIR_W +: PAIR_W];

    assign in_ready   = (r_state == ST_FILL);
    assign busy       = (r_state == ST_WAIT) || (r_state == ST_DRAIN);
    assign out_valid  = (r_state == ST_DRAIN);
    assign out_r      = out_valid ? w_out_sel[DATA_W-1:0]      : '0;
    assign out_i      = out_valid ? w_out_sel[PAIR_W-1:DATA_W] : '0;
    assign out_last   = out_valid && (r_rd_idx == LAST_IDX);
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire
